mux_scan: RTL

Parametrised, registered N-channel, W-bit multiplexer: the next generation of our 2:1 select block. It adds a selectable channel register, an automatic round-robin scan mode with a programmable dwell time, and a registered output with a valid flag. It sits between the datapath sources and the display/capture logic, which sample `out` only when `out_valid` is high.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/mux_dwell_ctr.sv | 34 +++
 rtl/mux_scan.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the scanning multiplexer: mode encoding, FSM states
// and the select-width helper.
package mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    // Smallest r with 2**r >= n; bounded loop keeps it elaboration-friendly.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            r = ((32'sd1 <<< r) < n) ? r + 32'sd1 : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_dwell_ctr.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled, flags the last count.
module mux_dwell_ctr
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_r;

    assign tc = (cnt_r == LAST);

    // Count register: clear wins over counting; wraps to zero on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= tc ? '0 : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with a loadable select register and a
// round-robin scan mode that dwells DWELL enabled cycles per channel.
module mux_scan
    import mux_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int N     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel_in,
    input  logic            sel_load,
    output logic [W-1:0]    out,
    output logic            out_valid,
    output logic [SW-1:0]   sel_cur,
    output logic            sel_chg,
    output logic            sel_err
);

    localparam logic [SW:0]   N_EXT = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N - 1);

    state_e        state_s;
    logic          load_ok_s;
    logic          err_s;
    logic [SW-1:0] sel_nxt_s;
    logic          dwell_en_s;
    logic          dwell_clr_s;
    logic          dwell_tc_s;

    logic [W-1:0]  out_r;
    logic          out_valid_r;
    logic [SW-1:0] sel_cur_r;
    logic          sel_chg_r;
    logic          sel_err_r;

    assign load_ok_s = sel_load && ({1'b0, sel_in} < N_EXT);

    // Operating state is a direct decode of the enable and mode inputs.
    always_comb begin
        state_s = ST_IDLE;
        if (!en) begin
            state_s = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
            state_s = ST_SCAN;
        end else begin
            state_s = ST_STATIC;
        end
    end

    // Next select, dwell control and load-error flag for the coming edge.
    always_comb begin
        sel_nxt_s   = sel_cur_r;
        dwell_en_s  = 1'b0;
        dwell_clr_s = 1'b0;
        err_s       = 1'b0;
        case (state_s)
            ST_IDLE: begin
                sel_nxt_s = sel_cur_r;
            end
            ST_STATIC: begin
                dwell_clr_s = 1'b1;
                err_s       = sel_load && !load_ok_s;
                if (load_ok_s) begin
                    sel_nxt_s = sel_in;
                end else begin
                    sel_nxt_s = sel_cur_r;
                end
            end
            ST_SCAN: begin
                err_s = sel_load && !load_ok_s;
                if (load_ok_s) begin
                    sel_nxt_s   = sel_in;
                    dwell_clr_s = 1'b1;
                end else begin
                    // A rejected load leaves the scan running untouched.
                    dwell_en_s = 1'b1;
                    if (dwell_tc_s) begin
                        sel_nxt_s = (sel_cur_r == LAST) ? '0 : sel_cur_r + SW'(1);
                    end else begin
                        sel_nxt_s = sel_cur_r;
                    end
                end
            end
            default: begin
                sel_nxt_s = sel_cur_r;
            end
        endcase
    end

    mux_dwell_ctr #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dwell_en_s),
        .clr   (dwell_clr_s),
        .tc    (dwell_tc_s)
    );

    // Output, select and pulse registers; IDLE freezes data and select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            sel_cur_r   <= '0;
            sel_chg_r   <= 1'b0;
            sel_err_r   <= 1'b0;
        end else begin
            if (state_s != ST_IDLE) begin
                out_r <= in_data[sel_cur_r*W +: W];
            end else begin
                out_r <= out_r;
            end
            out_valid_r <= (state_s != ST_IDLE);
            sel_cur_r   <= sel_nxt_s;
            sel_chg_r   <= (sel_nxt_s != sel_cur_r);
            sel_err_r   <= err_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign sel_cur   = sel_cur_r;
    assign sel_chg   = sel_chg_r;
    assign sel_err   = sel_err_r;

endmodule
